dmem_sync: RTL and testbench
============================

# dmem_sync

Parametrised, clocked data memory for the MIPS datapath, replacing the level-triggered word memory. Byte-addressed, little-endian; supports byte/halfword/word loads and stores with sign or zero extension, byte-lane write enables, alignment and range checking, and a configurable read latency behind a valid/ready request port with a single-cycle response strobe. Sits between the MEM stage and the core's stall logic; one request outstanding at a time.

## Interface
- DEPTH, 512: number of 32-bit words; power of two, ≥ 4
- LAT, 1: cycles from request accept to `resp_valid`; 1..4
- ADDR_W, 32: byte-address width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when `req_valid && req_ready`
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified (LSBs)
- resp_valid  out  1  one-cycle pulse: response for the accepted request
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out of range, or reserved size

## Operation
- Word index = `req_addr[log2(DEPTH)+1:2]`. Out of range when `req_addr >= DEPTH*4`.
- Misaligned: half with `addr[0]=1`; word with `addr[1:0]!=0`. Reserved size is an error.
- Error requests: no array write; response carries `resp_err=1`, `resp_rdata=0`.
- Store (valid): committed to the array on the accept edge. Byte lane = `addr[1:0]`; half lane = `addr[1]`. Data is replicated into the lanes; only the addressed byte enables are asserted.
- Load: the word is read on the accept edge. The lane is extracted: byte `[8*a+7:8*a]`; half `[16*h+15:16*h]`. The result is extended to 32 bits per `req_unsigned` and held in a response register.
- FSM states (shared package enum): IDLE, WAIT, RESP.
  - IDLE: on accept → RESP if LAT=1, else WAIT with the counter loaded to LAT-2.
  - WAIT: counter decrements each cycle; → RESP when the counter is 0.
  - RESP: `resp_valid=1` for exactly this cycle. An accept in this cycle → WAIT/RESP as from IDLE; no accept → IDLE.
- `req_ready = (state==IDLE) || (state==RESP)`. Back-to-back requests yield a response every LAT+… cycles, with no bubble beyond LAT.
- Store followed by a load to the same word: the load observes the new data, because the store committed at its own accept.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, counter 0.
- Latency: a request accepted at edge N gives `resp_valid` high in the cycle after edge N+LAT-1. Example: LAT=1 → response in the cycle immediately after accept.
- All outputs are registered except `req_ready`, which is decoded from state.
- Reset mid-operation (WAIT/RESP): the response is dropped and the FSM returns to IDLE. A store accepted before reset remains committed.
- `req_*` inputs are ignored when `req_valid=0` or `req_ready=0`. No response is generated for a non-accepted request.

## Structure
- `dmem_pkg`: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, `LAT_MAX=4`.
- Sub-module `dmem_array`: DEPTH×32 storage with a 4-bit byte-write-enable and synchronous read on the same edge (read-before-write on the same address).
- Top level: decode/check logic, lane steering and extension, FSM, latency counter.

## Test plan
- Reset with `rst_n=0` while `req_valid=1` → `req_ready=1`, `resp_valid=0`, no write; after release, an idle bus gives no response.
- LAT=1: SW 0x8 ← 0xDEADBEEF, then LW 0x8 → `resp_rdata=0xDEADBEEF`, `err=0`, one cycle after each accept.
- SB 0x9 ← 0x80, then LB 0x9 → 0xFFFFFF80; LBU 0x9 → 0x00000080; LW 0x8 → 0xDEAD80EF.
- SH 0xA ← 0x1234 → LH 0xA = 0x00001234; LW 0x8 → 0x123480EF.
- Misaligned LW 0x6, LH 0x3, size=11, and address DEPTH*4 → each gives `resp_err=1`, `rdata=0`; a following LW of those words is unchanged.
- LAT=3, back-to-back accepts in RESP: responses exactly 3 cycles apart. Reset asserted in WAIT → no `resp_valid`; the accepted store is still readable afterward.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the clocked data memory.
//   SZ_*          request size encodings (req_size)
//   dmem_state_t  response FSM state
//   LAT_MAX       largest supported read latency
//   extend_load   lane extraction plus sign/zero extension of a load word
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int LAT_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  // Pick the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: extend_load = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: extend_load = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
      default: extend_load = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32-bit storage with per-byte write enables.
//   clk    rising-edge clock
//   rd_en  capture mem[idx] into rdata on this edge (old contents)
//   be     byte write enables, bit b writes wdata[8b+7:8b]
//   idx    word index
//   wdata  write data, already replicated into lanes
//   rdata  registered read word, held until the next rd_en
// Contents are not reset.
module dmem_array #(
  parameter int DEPTH = 512,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) rdata <= mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/dmem_sync.sv
// dmem_sync: clocked byte-addressed little-endian data memory with a
// valid/ready request port and a one-cycle response strobe.
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake: accepted when both are high on an edge
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned      loads: 1 = zero-extend, 0 = sign-extend
//   req_addr          byte address
//   req_wdata         store data, right-justified
//   resp_valid        one-cycle pulse LAT cycles after accept
//   resp_rdata        extended load data; 0 for stores and errors
//   resp_err          misaligned, out of range, or reserved size
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high in IDLE and RESP, so one request is outstanding at a time and
// a new one may be accepted in the same cycle the previous response is strobed.
module dmem_sync
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int LAT    = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] CNT_LOAD = (LAT >= 2) ? 2'(LAT - 2) : 2'd0;

  dmem_state_t state, state_n;
  logic [1:0]  cnt, cnt_n;

  logic        accept, oor, misalign, err;
  logic [3:0]  be;
  logic [31:0] wdata_rep, arr_rdata;

  // Attributes of the accepted request, needed when the response is formed.
  logic        p_load;
  logic        p_err;
  logic [1:0]  p_size;
  logic [1:0]  p_lane;
  logic        p_unsigned;

  assign req_ready = (state == ST_IDLE) || (state == ST_RESP);
  // Gate with rst_n so a request held during reset never writes the array.
  assign accept    = req_valid && req_ready && rst_n;

  // DEPTH is a power of two, so any set bit above the index is out of range.
  assign oor      = |req_addr[ADDR_W-1:IDX_W+2];
  assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign err      = oor || misalign || (req_size == SZ_RSVD);

  always_comb begin
    be        = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        be        = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!(accept && req_we && !err)) be = 4'b0000;
  end

  dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .rd_en (accept && !req_we && !err),
    .be    (be),
    .idx   (req_addr[IDX_W+1:2]),
    .wdata (wdata_rep),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_WAIT: begin
        if (cnt == 2'd0) state_n = ST_RESP;
        else             cnt_n   = cnt - 2'd1;
      end
      default: begin
        // IDLE and RESP both accept; RESP falls back to IDLE otherwise.
        if (accept) begin
          if (LAT == 1) begin
            state_n = ST_RESP;
          end else begin
            state_n = ST_WAIT;
            cnt_n   = CNT_LOAD;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      resp_valid <= 1'b0;
      p_load     <= 1'b0;
      p_err      <= 1'b0;
      p_size     <= SZ_WORD;
      p_lane     <= 2'd0;
      p_unsigned <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      resp_valid <= (state_n == ST_RESP);
      if (accept) begin
        p_load     <= !req_we && !err;
        p_err      <= err;
        p_size     <= req_size;
        p_lane     <= req_addr[1:0];
        p_unsigned <= req_unsigned;
      end
    end
  end

  // The array's read register holds the loaded word; steering and extension
  // are applied to that held word, masked to 0 for stores and errors.
  assign resp_rdata = p_load ? extend_load(arr_rdata, p_size, p_lane, p_unsigned) : 32'd0;
  assign resp_err   = p_err;

endmodule

// File: tb/tb_dmem_sync.sv
// tb_dmem_sync: directed bench for dmem_sync; one instance with LAT=1 and one
// with LAT=3, both DEPTH=16 (address 64 is the first out-of-range byte).
module tb_dmem_sync;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b10;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              v1 = 1'b0, v3 = 1'b0;
  logic              ready1, rv1, err1, ready3, rv3, err3;
  logic [31:0]       rd1, rd3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_sync #(.DEPTH(DEPTH), .LAT(1), .ADDR_W(ADDR_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(ready1),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1));

  dmem_sync #(.DEPTH(DEPTH), .LAT(3), .ADDR_W(ADDR_W)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(ready3),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
  endtask

  // One full transaction on dut1 (sel=0, LAT=1) or dut3 (sel=1, LAT=3):
  // drive after a falling edge, accept on the next rising edge, then check
  // resp_valid is low before cycle LAT, high at LAT, low again at LAT+1.
  task automatic txn(input int sel, input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int lat;
    lat = (sel == 0) ? 1 : 3;
    @(negedge clk);
    set_req(we, size, uns, addr, wdata);
    v1 = (sel == 0); v3 = (sel != 0);
    check({tag, "_ready"}, {31'd0, (sel == 0) ? ready1 : ready3}, 32'd1);
    @(posedge clk);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      v1 = 1'b0; v3 = 1'b0;
      if (k < lat)
        check({tag, "_early"}, {31'd0, (sel == 0) ? rv1 : rv3}, 32'd0);
      if (k == lat) begin
        check({tag, "_valid"}, {31'd0, (sel == 0) ? rv1 : rv3}, 32'd1);
        check({tag, "_rdata"}, (sel == 0) ? rd1 : rd3, exp_rdata);
        check({tag, "_err"}, {31'd0, (sel == 0) ? err1 : err3}, {31'd0, exp_err});
      end
      if (k == lat + 1)
        check({tag, "_pulse"}, {31'd0, (sel == 0) ? rv1 : rv3}, 32'd0);
    end
  endtask

  initial begin
    // Reset with a store held on the bus.
    rst_n = 1'b0;
    set_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h2222_2222);
    v1 = 1'b1; v3 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready1", {31'd0, ready1}, 32'd1);
    check("rst_rv1", {31'd0, rv1}, 32'd0);
    check("rst_rdata1", rd1, 32'd0);
    check("rst_err1", {31'd0, err1}, 32'd0);
    check("rst_ready3", {31'd0, ready3}, 32'd1);
    check("rst_rv3", {31'd0, rv3}, 32'd0);
    v1 = 1'b0; v3 = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("idle_rv1", {31'd0, rv1}, 32'd0);
      check("idle_rv3", {31'd0, rv3}, 32'd0);
    end

    // Word 0 written, then a store held through reset must not land.
    txn(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h1111_1111, 32'h0, 1'b0, "sw0");
    @(negedge clk);
    rst_n = 1'b0;
    set_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h2222_2222);
    v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    rst_n = 1'b1;
    txn(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 1'b0, "lw0_norstwr");

    // LAT=1 word, byte and half traffic.
    txn(0, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw8");
    txn(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw8");
    txn(0, 1'b1, 2'b00, 1'b0, 32'h9, 32'hFFFF_FF80, 32'h0, 1'b0, "sb9");
    txn(0, 1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 32'hFFFF_FF80, 1'b0, "lb9");
    txn(0, 1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 32'h0000_0080, 1'b0, "lbu9");
    txn(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_80EF, 1'b0, "lw8_sb");
    txn(0, 1'b1, 2'b01, 1'b0, 32'hA, 32'hFFFF_1234, 32'h0, 1'b0, "sha");
    txn(0, 1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'h0000_1234, 1'b0, "lha");
    txn(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h1234_80EF, 1'b0, "lw8_sh");
    txn(0, 1'b0, 2'b01, 1'b0, 32'h8, 32'h0, 32'hFFFF_80EF, 1'b0, "lh8_neg");
    txn(0, 1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 32'h0000_0012, 1'b0, "lbb_pos");
    txn(0, 1'b1, 2'b10, 1'b0, 32'h3C, 32'h0BAD_F00D, 32'h0, 1'b0, "sw_last");
    txn(0, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0BAD_F00D, 1'b0, "lw_last");

    // Error cases: no write, rdata 0, err 1.
    txn(0, 1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFE_F00D, 32'h0, 1'b0, "sw4");
    txn(0, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, "lw6_mis");
    txn(0, 1'b1, 2'b10, 1'b0, 32'h6, 32'hFFFF_FFFF, 32'h0, 1'b1, "sw6_mis");
    txn(0, 1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1, "lh3_mis");
    txn(0, 1'b1, 2'b01, 1'b0, 32'h3, 32'h0000_AAAA, 32'h0, 1'b1, "sh3_mis");
    txn(0, 1'b1, 2'b11, 1'b0, 32'h4, 32'h5555_5555, 32'h0, 1'b1, "rsvd_size");
    txn(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h7777_7777, 32'h0, 1'b1, "sw_oor");
    txn(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, "lw_oor");
    txn(0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hCAFE_F00D, 1'b0, "lw4_kept");
    txn(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 1'b0, "lw0_kept");

    // LAT=3: single transaction, then a second request accepted in RESP.
    txn(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hA5A5_A5A5, 32'h0, 1'b0, "l3_sw10");
    @(negedge clk);
    set_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    v3 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) v3 = 1'b0;
      check("l3_b2b_valid", {31'd0, rv3}, {31'd0, (k == 3) || (k == 6)});
      if (k == 3) begin
        check("l3_b2b_rdata1", rd3, 32'hA5A5_A5A5);
        check("l3_b2b_ready", {31'd0, ready3}, 32'd1);
        set_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        v3 = 1'b1;
      end
      if (k == 4) v3 = 1'b0;
      if (k == 6) check("l3_b2b_rdata2", rd3, 32'h0000_00A5);
    end

    // LAT=3: reset while in WAIT drops the response, store stays.
    @(negedge clk);
    set_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h600D_CAFE);
    v3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    check("l3_wait_ready", {31'd0, ready3}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("l3_rst_ready", {31'd0, ready3}, 32'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("l3_rst_norsp", {31'd0, rv3}, 32'd0);
    end
    txn(1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h600D_CAFE, 1'b0, "l3_lw14");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
